sync_ptr_gray: RTL and testbench

- Parametrised successor to the fixed 8-bit, two-flop pointer synchroniser.
- Brings a Gray-coded FIFO pointer from the opposite clock domain into the local clock domain through a configurable flop chain.
- Converts the pointer to binary and reports updates, advance amount and illegal multi-bit Gray steps.
- Used on both the read side and the write side of the transmitter FIFO to generate full/empty conditions.

---
 rtl/sync_ptr_gray_if.sv | 35 +++
 rtl/sync_ptr_gray.sv | 121 ++++++++++++
 tb/tb_sync_ptr_gray.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_ptr_gray_if.sv
// Pointer synchroniser bus: pointer from the far clock domain in, synchronised
// pointer, update pulse, advance amount and step-error flag out.
interface sync_ptr_gray_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ptr_async;
    logic             err_clr;
    logic [WIDTH-1:0] ptr_sync;
    logic [WIDTH-1:0] ptr_sync_gray;
    logic             ptr_update;
    logic [WIDTH-1:0] ptr_delta;
    logic             step_err;

    // Side that owns the far-domain pointer and consumes the results.
    modport master (
        output ptr_async,
        output err_clr,
        input  ptr_sync,
        input  ptr_sync_gray,
        input  ptr_update,
        input  ptr_delta,
        input  step_err
    );

    // The synchroniser itself.
    modport slave (
        input  ptr_async,
        input  err_clr,
        output ptr_sync,
        output ptr_sync_gray,
        output ptr_update,
        output ptr_delta,
        output step_err
    );
endinterface

// File: rtl/sync_ptr_gray.sv
// Gray-coded FIFO pointer synchroniser.
// Brings a pointer from the opposite clock domain through a STAGES-deep flop
// chain, converts it to binary, and reports when it moved, by how much, and
// whether the move was an illegal multi-bit Gray step.
module sync_ptr_gray #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int GRAY_IN = 1,
    parameter int CHECK   = 1
) (
    input  logic          clk,
    input  logic          rst,
    sync_ptr_gray_if.slave bus
);

    // Refuse to build outside the supported parameter ranges.
    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_ptr_gray: STAGES must be in 2..4");
        end
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("sync_ptr_gray: WIDTH must be in 2..16");
        end
    endgenerate

    // The step check only makes sense for a Gray-coded source.
    localparam bit CHECK_EN = (GRAY_IN != 0) && (CHECK != 0);

    // Standard Gray to binary: each binary bit is the XOR of all Gray bits at
    // and above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves
    // something behind.
    function automatic logic multi_bit(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) != {WIDTH{1'b0}};
    endfunction

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] last_s;
    logic [WIDTH-1:0] bin_s;
    logic             changed_s;
    logic             step_bad_s;

    logic [WIDTH-1:0] ptr_sync_r;
    logic [WIDTH-1:0] ptr_sync_gray_r;
    logic             ptr_update_r;
    logic [WIDTH-1:0] ptr_delta_r;
    logic             step_err_r;

    // Synchroniser chain; the first flop samples the far-domain pointer raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.ptr_async;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign last_s = sync_r[STAGES-1];

    // Decode the settled pointer and compare it with what was last published.
    always_comb begin
        bin_s      = last_s;
        step_bad_s = 1'b0;
        if (GRAY_IN != 0) begin
            bin_s = gray_to_bin(last_s);
        end else begin
            bin_s = last_s;
        end
        changed_s = (last_s != ptr_sync_gray_r);
        if (CHECK_EN) begin
            step_bad_s = multi_bit(last_s ^ ptr_sync_gray_r);
        end else begin
            step_bad_s = 1'b0;
        end
    end

    // Output stage: publish the pointer, pulse on change, capture the advance
    // and latch illegal steps (a new error beats a simultaneous clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_sync_r      <= {WIDTH{1'b0}};
            ptr_sync_gray_r <= {WIDTH{1'b0}};
            ptr_update_r    <= 1'b0;
            ptr_delta_r     <= {WIDTH{1'b0}};
            step_err_r      <= 1'b0;
        end else begin
            ptr_sync_gray_r <= last_s;
            ptr_sync_r      <= bin_s;
            ptr_update_r    <= changed_s;
            if (changed_s) begin
                ptr_delta_r <= bin_s - ptr_sync_r;
            end
            if (changed_s && step_bad_s) begin
                step_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                step_err_r <= 1'b0;
            end
        end
    end

    assign bus.ptr_sync      = ptr_sync_r;
    assign bus.ptr_sync_gray = ptr_sync_gray_r;
    assign bus.ptr_update    = ptr_update_r;
    assign bus.ptr_delta     = ptr_delta_r;
    assign bus.step_err      = step_err_r;

endmodule

// File: tb/tb_sync_ptr_gray.sv
// Scoreboard bench for sync_ptr_gray. Stimulus pushes the expected update
// (cycle, pointer, delta, error flag) into a per-instance queue; monitors pop
// and compare whenever an instance pulses ptr_update.
module tb_sync_ptr_gray;

    typedef struct {
        int cyc;
        int sync;
        int delta;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    sync_ptr_gray_if #(.WIDTH(8)) bus_a ();
    sync_ptr_gray_if #(.WIDTH(8)) bus_b ();
    sync_ptr_gray_if #(.WIDTH(4)) bus_c ();

    sync_ptr_gray #(.WIDTH(8), .STAGES(2), .GRAY_IN(1), .CHECK(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a));
    sync_ptr_gray #(.WIDTH(8), .STAGES(3), .GRAY_IN(1), .CHECK(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b));
    sync_ptr_gray #(.WIDTH(4), .STAGES(2), .GRAY_IN(0), .CHECK(1)) dut_c (
        .clk(clk), .rst(rst_c), .bus(bus_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_update(input string tag, input exp_t e,
                                input int s, input int d, input int er);
        cmp({tag, "_latency"}, cyc, e.cyc);
        cmp({tag, "_ptr_sync"}, s, e.sync);
        cmp({tag, "_ptr_delta"}, d, e.delta);
        cmp({tag, "_step_err"}, er, e.err);
    endtask

    task automatic push(input int which, input int lat, input int s,
                        input int d, input int er);
        exp_t e;
        e = '{cyc: cyc + lat, sync: s, delta: d, err: er};
        case (which)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    function automatic logic [7:0] gray8(input int v);
        logic [7:0] b;
        b = 8'(v);
        return b ^ (b >> 1);
    endfunction

    // Monitors: sample away from the active edge.
    always @(negedge clk) begin
        if (bus_a.ptr_update === 1'b1) begin
            if (q_a.size() == 0) cmp("A_spurious_update", int'(bus_a.ptr_update), 0);
            else check_update("A", q_a.pop_front(), int'(bus_a.ptr_sync),
                              int'(bus_a.ptr_delta), int'(bus_a.step_err));
        end
    end

    always @(negedge clk) begin
        if (bus_b.ptr_update === 1'b1) begin
            if (q_b.size() == 0) cmp("B_spurious_update", int'(bus_b.ptr_update), 0);
            else check_update("B", q_b.pop_front(), int'(bus_b.ptr_sync),
                              int'(bus_b.ptr_delta), int'(bus_b.step_err));
        end
    end

    always @(negedge clk) begin
        if (bus_c.ptr_update === 1'b1) begin
            if (q_c.size() == 0) cmp("C_spurious_update", int'(bus_c.ptr_update), 0);
            else check_update("C", q_c.pop_front(), int'(bus_c.ptr_sync),
                              int'(bus_c.ptr_delta), int'(bus_c.step_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++) begin
            tick();
        end
        cmp({name, "_pending"}, q_a.size() + q_b.size() + q_c.size(), 0);
        repeat (3) tick();
    endtask

    logic [7:0] b2b_vec [5];

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        bus_a.ptr_async = 8'h00;
        bus_b.ptr_async = 8'h00;
        bus_c.ptr_async = 4'h0;
        bus_a.err_clr = 1'b0;
        bus_b.err_clr = 1'b0;
        bus_c.err_clr = 1'b0;
        b2b_vec = '{8'h03, 8'h02, 8'h06, 8'h07, 8'h05};

        // Reset state.
        repeat (3) tick();
        cmp("rst_ptr_sync", int'(bus_a.ptr_sync), 0);
        cmp("rst_ptr_sync_gray", int'(bus_a.ptr_sync_gray), 0);
        cmp("rst_ptr_update", int'(bus_a.ptr_update), 0);
        cmp("rst_ptr_delta", int'(bus_a.ptr_delta), 0);
        cmp("rst_step_err", int'(bus_a.step_err), 0);
        cmp("rst_b_ptr_sync", int'(bus_b.ptr_sync), 0);
        cmp("rst_c_ptr_sync", int'(bus_c.ptr_sync), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (5) tick();

        // First update and latency: gray(1) = 0x01.
        bus_a.ptr_async = 8'h01;
        push(0, 3, 1, 1, 0);
        drain("first");
        cmp("first_gray_out", int'(bus_a.ptr_sync_gray), 1);

        // Back-to-back: gray 2..6 on consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            bus_a.ptr_async = b2b_vec[i];
            push(0, 3, i + 2, 1, 0);
            tick();
        end
        drain("b2b");

        // Gray count sweep 7..255 and wrap to 0.
        for (int v = 7; v <= 256; v++) begin
            bus_a.ptr_async = gray8(v % 256);
            push(0, 3, v % 256, 1, 0);
            repeat (4) tick();
        end
        drain("sweep");
        cmp("sweep_step_err", int'(bus_a.step_err), 0);

        // Illegal step 0x00 -> 0x03.
        bus_a.ptr_async = 8'h03;
        push(0, 3, 2, 2, 1);
        drain("illegal");
        cmp("illegal_sticky", int'(bus_a.step_err), 1);
        bus_a.err_clr = 1'b1;
        tick();
        bus_a.err_clr = 1'b0;
        cmp("err_clr_clears", int'(bus_a.step_err), 0);

        // 0x03 -> 0x0C with err_clr on the detection edge: set wins.
        bus_a.ptr_async = 8'h0C;
        push(0, 3, 8, 6, 1);
        tick();
        tick();
        bus_a.err_clr = 1'b1;
        tick();
        bus_a.err_clr = 1'b0;
        drain("set_wins");
        cmp("set_wins_sticky", int'(bus_a.step_err), 1);

        // Reset mid-flight on the 3-stage instance.
        bus_b.ptr_async = 8'h05;
        tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        cmp("midrst_ptr_sync", int'(bus_b.ptr_sync), 0);
        cmp("midrst_ptr_update", int'(bus_b.ptr_update), 0);
        push(1, 4, 6, 6, 1);
        drain("midrst");

        // Binary pass-through, WIDTH=4.
        bus_c.ptr_async = 4'd3;
        push(2, 3, 3, 3, 0);
        drain("bin_first");
        bus_c.ptr_async = 4'd9;
        push(2, 3, 9, 6, 0);
        drain("bin_second");
        cmp("bin_step_err", int'(bus_c.step_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
